// File: rtl/video_timing_pkg.sv
// Tank Battalion raster defaults and a timing-parameter record for alternate video modes.
package video_timing_pkg;

  localparam int unsigned TB_CLK_DIV      = 4;
  localparam int unsigned TB_H_TOTAL      = 384;
  localparam int unsigned TB_H_ACTIVE     = 256;
  localparam int unsigned TB_H_SYNC_START = 288;
  localparam int unsigned TB_H_SYNC_WIDTH = 32;
  localparam int unsigned TB_V_TOTAL      = 264;
  localparam int unsigned TB_V_ACTIVE     = 224;
  localparam int unsigned TB_V_SYNC_START = 240;
  localparam int unsigned TB_V_SYNC_WIDTH = 8;
  localparam int unsigned TB_IRQ_LINE     = 224;

  typedef struct packed {
    int unsigned clk_div;
    int unsigned h_total;
    int unsigned h_active;
    int unsigned h_sync_start;
    int unsigned h_sync_width;
    int unsigned v_total;
    int unsigned v_active;
    int unsigned v_sync_start;
    int unsigned v_sync_width;
    int unsigned irq_line;
  } timing_t;

  localparam timing_t TB_TIMING = '{
    clk_div:      TB_CLK_DIV,
    h_total:      TB_H_TOTAL,
    h_active:     TB_H_ACTIVE,
    h_sync_start: TB_H_SYNC_START,
    h_sync_width: TB_H_SYNC_WIDTH,
    v_total:      TB_V_TOTAL,
    v_active:     TB_V_ACTIVE,
    v_sync_start: TB_V_SYNC_START,
    v_sync_width: TB_V_SYNC_WIDTH,
    irq_line:     TB_IRQ_LINE
  };

  function automatic bit timing_legal(timing_t t);
    return (t.clk_div >= 1) &&
           (t.h_active <= t.h_total) && (t.v_active <= t.v_total) &&
           (t.h_sync_start + t.h_sync_width <= t.h_total) &&
           (t.v_sync_start + t.v_sync_width <= t.v_total) &&
           (t.irq_line < t.v_total) &&
           (t.h_total >= 8) && (t.h_total % 8 == 0);
  endfunction

endpackage

// File: rtl/video_timing_gen_mod_counter.sv
// Modulus-N counter with enable, synchronous active-low clear and terminal-count flag.
module mod_counter #(
  parameter int unsigned Modulus = 4,
  parameter int unsigned Width   = (Modulus > 1) ? $clog2(Modulus) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  localparam logic [Width-1:0] Last = Width'(Modulus - 1);

  logic [Width-1:0] count_d, count_q;

  assign tc_o    = (count_q == Last);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, sync/blank decode,
// tile load strobe and VBLANK IRQ/NMI.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV      = TB_CLK_DIV,
  parameter int unsigned H_TOTAL      = TB_H_TOTAL,
  parameter int unsigned H_ACTIVE     = TB_H_ACTIVE,
  parameter int unsigned H_SYNC_START = TB_H_SYNC_START,
  parameter int unsigned H_SYNC_WIDTH = TB_H_SYNC_WIDTH,
  parameter int unsigned V_TOTAL      = TB_V_TOTAL,
  parameter int unsigned V_ACTIVE     = TB_V_ACTIVE,
  parameter int unsigned V_SYNC_START = TB_V_SYNC_START,
  parameter int unsigned V_SYNC_WIDTH = TB_V_SYNC_WIDTH,
  parameter int unsigned IRQ_LINE     = TB_IRQ_LINE,
  parameter int unsigned HW           = $clog2(H_TOTAL),
  parameter int unsigned VW           = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          csync_mode,
  input  logic          irq_ack,
  input  logic          nmi_en,
  output logic          pix_ce,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          csync_n,
  output logic          tile_ld,
  output logic          line_start,
  output logic          frame_start,
  output logic          irq_n,
  output logic          nmi_n
);

  localparam timing_t Cfg = '{
    clk_div:      CLK_DIV,
    h_total:      H_TOTAL,
    h_active:     H_ACTIVE,
    h_sync_start: H_SYNC_START,
    h_sync_width: H_SYNC_WIDTH,
    v_total:      V_TOTAL,
    v_active:     V_ACTIVE,
    v_sync_start: V_SYNC_START,
    v_sync_width: V_SYNC_WIDTH,
    irq_line:     IRQ_LINE
  };

  if (!timing_legal(Cfg)) begin : g_param_check
    $error("video_timing_gen: illegal timing parameters");
  end

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] unused_div_count;
  logic            div_tc, h_tc, v_tc_unused;
  logic            pix_ce_d, pix_ce_q;
  logic            irq_d, irq_q;
  logic            nmi_n_d, nmi_n_q;
  logic            irq_set;
  logic            hsync_raw_n;
  logic [31:0]     hc_ext, vc_ext;

  mod_counter #(
    .Modulus (CLK_DIV),
    .Width   (DivW)
  ) u_div (
    .clk_i   (clk),
    .rst_ni  (nRESET),
    .en_i    (1'b1),
    .count_o (unused_div_count),
    .tc_o    (div_tc)
  );

  mod_counter #(
    .Modulus (H_TOTAL),
    .Width   (HW)
  ) u_hcnt (
    .clk_i   (clk),
    .rst_ni  (nRESET),
    .en_i    (pix_ce_q),
    .count_o (hcount),
    .tc_o    (h_tc)
  );

  mod_counter #(
    .Modulus (V_TOTAL),
    .Width   (VW)
  ) u_vcnt (
    .clk_i   (clk),
    .rst_ni  (nRESET),
    .en_i    (pix_ce_q & h_tc),
    .count_o (vcount),
    .tc_o    (v_tc_unused)
  );

  // Widen once so every decode compares against full-width parameters.
  assign hc_ext = 32'(hcount);
  assign vc_ext = 32'(vcount);

  assign pix_ce      = pix_ce_q;
  assign hblank      = (hc_ext >= H_ACTIVE);
  assign vblank      = (vc_ext >= V_ACTIVE);
  assign hsync_raw_n = ~((hc_ext >= H_SYNC_START) && (hc_ext < H_SYNC_START + H_SYNC_WIDTH));
  assign vsync_n     = ~((vc_ext >= V_SYNC_START) && (vc_ext < V_SYNC_START + V_SYNC_WIDTH));
  assign csync_n     = hsync_raw_n & vsync_n;
  assign hsync_n     = csync_mode ? csync_n : hsync_raw_n;

  assign tile_ld     = pix_ce_q & (hcount[2:0] == 3'd7);
  assign line_start  = pix_ce_q & (hcount == '0);
  assign frame_start = line_start & (vcount == '0);

  assign irq_set     = line_start & (vc_ext == IRQ_LINE);
  assign irq_n       = ~irq_q;
  assign nmi_n       = nmi_n_q;

  always_comb begin
    pix_ce_d = div_tc;
    nmi_n_d  = ~(vblank & nmi_en);
    irq_d    = irq_q;
    if (irq_ack) begin
      irq_d = 1'b0;
    end
    // A new request in the same clk as the acknowledge must not be lost.
    if (irq_set) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      pix_ce_q <= 1'b0;
      irq_q    <= 1'b0;
      nmi_n_q  <= 1'b1;
    end else begin
      pix_ce_q <= pix_ce_d;
      irq_q    <= irq_d;
      nmi_n_q  <= nmi_n_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench: two generators (CLK_DIV 2 and 1) on a small raster, checked against an
// arithmetic model that derives all outputs from the clock count since reset release.
module tb_video_timing_gen;

  localparam int unsigned HT = 16, HA = 10, HSS = 11, HSW = 3;
  localparam int unsigned VT = 12, VA = 8, VSS = 9, VSW = 2, IRQL = 8;
  localparam int unsigned HW = $clog2(HT), VW = $clog2(VT);
  localparam int unsigned P1 = 1200, P2 = 3200, NCYC = 4100;

  logic clk = 1'b0;
  logic nRESET = 1'b0, csync_mode = 1'b0, irq_ack = 1'b0, nmi_en = 1'b0;

  logic [1:0] pix_ce, hblank, vblank, hsync_n, vsync_n, csync_n;
  logic [1:0] tile_ld, line_start, frame_start, irq_n, nmi_n;
  logic [HW-1:0] hcount [2];
  logic [VW-1:0] vcount [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW), .IRQ_LINE(IRQL)
  ) dut0 (
    .clk(clk), .nRESET(nRESET), .csync_mode(csync_mode), .irq_ack(irq_ack), .nmi_en(nmi_en),
    .pix_ce(pix_ce[0]), .hcount(hcount[0]), .vcount(vcount[0]), .hblank(hblank[0]),
    .vblank(vblank[0]), .hsync_n(hsync_n[0]), .vsync_n(vsync_n[0]), .csync_n(csync_n[0]),
    .tile_ld(tile_ld[0]), .line_start(line_start[0]), .frame_start(frame_start[0]),
    .irq_n(irq_n[0]), .nmi_n(nmi_n[0])
  );

  video_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW), .IRQ_LINE(IRQL)
  ) dut1 (
    .clk(clk), .nRESET(nRESET), .csync_mode(csync_mode), .irq_ack(irq_ack), .nmi_en(nmi_en),
    .pix_ce(pix_ce[1]), .hcount(hcount[1]), .vcount(vcount[1]), .hblank(hblank[1]),
    .vblank(vblank[1]), .hsync_n(hsync_n[1]), .vsync_n(vsync_n[1]), .csync_n(csync_n[1]),
    .tile_ld(tile_ld[1]), .line_start(line_start[1]), .frame_start(frame_start[1]),
    .irq_n(irq_n[1]), .nmi_n(nmi_n[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // m = rising edges with nRESET high since the last reset edge.
  function automatic bit pce_of(input int unsigned m, input int unsigned d);
    return (m >= d) && (m % d == 0);
  endfunction

  function automatic int unsigned pix_of(input int unsigned m, input int unsigned d);
    return (m == 0) ? 0 : (m - 1) / d;
  endfunction

  task automatic check_dut(input int k, input int unsigned m, input int unsigned d,
                           input bit flag, input bit nmi_m);
    int unsigned pix, hc, vc;
    bit pce, hs, vs, cs, ls;
    string p;
    p   = (k == 0) ? "div2" : "div1";
    pce = pce_of(m, d);
    pix = pix_of(m, d);
    hc  = pix % HT;
    vc  = (pix / HT) % VT;
    hs  = !(hc >= HSS && hc < HSS + HSW);
    vs  = !(vc >= VSS && vc < VSS + VSW);
    cs  = hs && vs;
    ls  = pce && hc == 0;
    check({p, ".pix_ce"},      32'(pix_ce[k]),      32'(pce));
    check({p, ".hcount"},      32'(hcount[k]),      hc);
    check({p, ".vcount"},      32'(vcount[k]),      vc);
    check({p, ".hblank"},      32'(hblank[k]),      32'(hc >= HA));
    check({p, ".vblank"},      32'(vblank[k]),      32'(vc >= VA));
    check({p, ".hsync_n"},     32'(hsync_n[k]),     32'(csync_mode ? cs : hs));
    check({p, ".vsync_n"},     32'(vsync_n[k]),     32'(vs));
    check({p, ".csync_n"},     32'(csync_n[k]),     32'(cs));
    check({p, ".tile_ld"},     32'(tile_ld[k]),     32'(pce && hc % 8 == 7));
    check({p, ".line_start"},  32'(line_start[k]),  32'(ls));
    check({p, ".frame_start"}, 32'(frame_start[k]), 32'(ls && vc == 0));
    check({p, ".irq_n"},       32'(irq_n[k]),       32'(!flag));
    check({p, ".nmi_n"},       32'(nmi_n[k]),       32'(nmi_m));
  endtask

  initial begin
    int unsigned m [2];
    int unsigned dv [2];
    bit flag [2];
    bit nmi [2];
    bit rst_done;
    int unsigned pix0, hc0, vc0;
    bit set0;
    dv[0] = 2;
    dv[1] = 1;
    rst_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m[k] = 0;
      flag[k] = 1'b0;
      nmi[k] = 1'b1;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      // Advance the model using the inputs the DUTs just sampled.
      for (int k = 0; k < 2; k++) begin
        int unsigned px, hc, vc;
        bit pce;
        pce = pce_of(m[k], dv[k]);
        px  = pix_of(m[k], dv[k]);
        hc  = px % HT;
        vc  = (px / HT) % VT;
        if (!nRESET) begin
          m[k] = 0;
          flag[k] = 1'b0;
          nmi[k] = 1'b1;
        end else begin
          if (pce && hc == 0 && vc == IRQL) flag[k] = 1'b1;
          else if (irq_ack) flag[k] = 1'b0;
          nmi[k] = !(vc >= VA && nmi_en);
          m[k]++;
        end
      end
      #1;
      pix0 = pix_of(m[0], dv[0]);
      hc0  = pix0 % HT;
      vc0  = (pix0 / HT) % VT;
      set0 = pce_of(m[0], dv[0]) && hc0 == 0 && vc0 == IRQL;
      nRESET = (cyc >= 3);
      if ($urandom_range(7) == 0) csync_mode = ~csync_mode;
      if (cyc < P1) begin
        irq_ack = 1'b0;
        nmi_en  = ((cyc / 200) % 2) == 1;
      end else if (cyc < P2) begin
        irq_ack = ($urandom_range(29) == 0);
        if (set0) irq_ack = $urandom_range(1) == 1;
        if ($urandom_range(63) == 0) nmi_en = ~nmi_en;
        if ($urandom_range(699) == 0) nRESET = 1'b0;
      end else begin
        irq_ack = 1'b0;
        if (!rst_done && flag[0] && vc0 == IRQL + 2) begin
          nRESET = 1'b0;
          rst_done = 1'b1;
        end
      end
      #1;
      for (int k = 0; k < 2; k++) check_dut(k, m[k], dv[k], flag[k], nmi[k]);
    end

    check("mid_frame_reset_reached", 32'(rst_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
